// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared types and widths for the two-port bus arbiter.
package bus_arbiter_pkg;

    localparam int unsigned BUS_ADDR_W  = 16;
    localparam int unsigned BUS_DATA_W  = 16;
    localparam int unsigned GRANT_CNT_W = 16;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

    // Payload held in a pending register and driven onto the bus.
    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
        logic                  rw;
    } bus_req_t;

endpackage

// File: rtl/bus_arbiter_tag_fifo.sv
// tag_fifo: in-order record of which port issued each outstanding bus request.
module tag_fifo
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  port_id_t                push_id,
    input  logic                    pop,
    output port_id_t                head,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    port_id_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign head    = mem[rd_ptr];

    // Tag storage; stale entries are masked by the count, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin sharing of the core memory bus between two hosts,
// with in-order response routing through a tag FIFO.
// Optional BUS_ARBITER_STATS_EN adds saturating per-port grant counters.
// Payload widths follow bus_arbiter_pkg; ADDR_W/DATA_W must match them.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W          = BUS_ADDR_W,
    parameter int unsigned DATA_W          = BUS_DATA_W,
    parameter int unsigned MAX_OUTSTANDING = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      a_addr_i,
    input  logic [DATA_W-1:0]      a_wdata_i,
    input  logic                   a_rw_i,
    input  logic                   a_valid_i,
    input  logic [ADDR_W-1:0]      b_addr_i,
    input  logic [DATA_W-1:0]      b_wdata_i,
    input  logic                   b_rw_i,
    input  logic                   b_valid_i,
    output logic [DATA_W-1:0]      a_rdata_o,
    output logic                   a_rw_o,
    output logic                   a_valid_o,
    output logic [DATA_W-1:0]      b_rdata_o,
    output logic                   b_rw_o,
    output logic                   b_valid_o,
    output logic [ADDR_W-1:0]      addr_o,
    output logic [DATA_W-1:0]      wdata_o,
    output logic                   rw_o,
    output logic                   valid_o,
    input  logic [DATA_W-1:0]      bus_rdata_i,
    input  logic                   bus_rw_i,
    input  logic                   bus_valid_i,
    output logic                   a_overflow_o,
    output logic                   b_overflow_o,
    output logic                   spurious_o,
    output logic [GRANT_CNT_W-1:0] a_grants_o,
    output logic [GRANT_CNT_W-1:0] b_grants_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    bus_req_t         a_in;
    bus_req_t         b_in;
    bus_req_t         a_cur;
    bus_req_t         b_cur;
    bus_req_t         a_req_q;
    bus_req_t         b_req_q;
    logic             a_pend_q;
    logic             b_pend_q;
    port_id_t         rr_q;
    logic             a_elig;
    logic             b_elig;
    logic             gnt_a;
    logic             gnt_b;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic             fifo_full;
    port_id_t         push_id;
    port_id_t         fifo_head;
    logic [CNT_W-1:0] fifo_count_unused;

    tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .push_id (push_id),
        .pop     (fifo_pop),
        .head    (fifo_head),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count_unused)
    );

    // Eligibility (bypass or held) and round-robin grant; full uses pre-pop count.
    always_comb begin
        a_in       = '0;
        b_in       = '0;
        a_in.addr  = BUS_ADDR_W'(a_addr_i);
        a_in.wdata = BUS_DATA_W'(a_wdata_i);
        a_in.rw    = a_rw_i;
        b_in.addr  = BUS_ADDR_W'(b_addr_i);
        b_in.wdata = BUS_DATA_W'(b_wdata_i);
        b_in.rw    = b_rw_i;
        a_cur      = a_pend_q ? a_req_q : a_in;
        b_cur      = b_pend_q ? b_req_q : b_in;
        a_elig     = a_valid_i || a_pend_q;
        b_elig     = b_valid_i || b_pend_q;
        gnt_a      = !fifo_full && a_elig && (!b_elig || rr_q == PORT_B);
        gnt_b      = !fifo_full && b_elig && (!a_elig || rr_q == PORT_A);
        fifo_push  = gnt_a || gnt_b;
        push_id    = gnt_b ? PORT_B : PORT_A;
        fifo_pop   = bus_valid_i && !fifo_empty;
    end

    // Pending registers: refill on grant if a new request arrives, drop when busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_pend_q     <= 1'b0;
            b_pend_q     <= 1'b0;
            a_req_q      <= '0;
            b_req_q      <= '0;
            a_overflow_o <= 1'b0;
            b_overflow_o <= 1'b0;
        end else begin
            if (gnt_a) begin
                a_pend_q <= a_pend_q && a_valid_i;
                a_req_q  <= a_in;
            end else if (a_valid_i) begin
                if (a_pend_q) begin
                    a_overflow_o <= 1'b1;
                end else begin
                    a_pend_q <= 1'b1;
                    a_req_q  <= a_in;
                end
            end
            if (gnt_b) begin
                b_pend_q <= b_pend_q && b_valid_i;
                b_req_q  <= b_in;
            end else if (b_valid_i) begin
                if (b_pend_q) begin
                    b_overflow_o <= 1'b1;
                end else begin
                    b_pend_q <= 1'b1;
                    b_req_q  <= b_in;
                end
            end
        end
    end

    // Registered bus request and round-robin pointer (last granted port).
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            addr_o  <= '0;
            wdata_o <= '0;
            rw_o    <= 1'b0;
            rr_q    <= PORT_B;
        end else begin
            valid_o <= fifo_push;
            if (gnt_a) begin
                addr_o  <= ADDR_W'(a_cur.addr);
                wdata_o <= DATA_W'(a_cur.wdata);
                rw_o    <= a_cur.rw;
                rr_q    <= PORT_A;
            end else if (gnt_b) begin
                addr_o  <= ADDR_W'(b_cur.addr);
                wdata_o <= DATA_W'(b_cur.wdata);
                rw_o    <= b_cur.rw;
                rr_q    <= PORT_B;
            end
        end
    end

    // Response routing by head tag; responses with no tag are flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_o  <= 1'b0;
            b_valid_o  <= 1'b0;
            a_rdata_o  <= '0;
            b_rdata_o  <= '0;
            a_rw_o     <= 1'b0;
            b_rw_o     <= 1'b0;
            spurious_o <= 1'b0;
        end else begin
            a_valid_o <= fifo_pop && (fifo_head == PORT_A);
            b_valid_o <= fifo_pop && (fifo_head == PORT_B);
            if (fifo_pop && fifo_head == PORT_A) begin
                a_rdata_o <= bus_rdata_i;
                a_rw_o    <= bus_rw_i;
            end
            if (fifo_pop && fifo_head == PORT_B) begin
                b_rdata_o <= bus_rdata_i;
                b_rw_o    <= bus_rw_i;
            end
            if (bus_valid_i && fifo_empty) begin
                spurious_o <= 1'b1;
            end
        end
    end

`ifdef BUS_ARBITER_STATS_EN
    logic [GRANT_CNT_W-1:0] a_cnt_q;
    logic [GRANT_CNT_W-1:0] b_cnt_q;

    // Saturating per-port grant counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_cnt_q <= '0;
            b_cnt_q <= '0;
        end else begin
            if (gnt_a && a_cnt_q != '1) begin
                a_cnt_q <= a_cnt_q + GRANT_CNT_W'(1);
            end
            if (gnt_b && b_cnt_q != '1) begin
                b_cnt_q <= b_cnt_q + GRANT_CNT_W'(1);
            end
        end
    end

    assign a_grants_o = a_cnt_q;
    assign b_grants_o = b_cnt_q;
`else
    assign a_grants_o = '0;
    assign b_grants_o = '0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of arbitration, routing, overflow, full FIFO and reset.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a_addr_i, b_addr_i, a_wdata_i, b_wdata_i;
    logic        a_rw_i, b_rw_i, a_valid_i, b_valid_i;
    logic [15:0] a_rdata_o, b_rdata_o;
    logic        a_rw_o, b_rw_o, a_valid_o, b_valid_o;
    logic [15:0] addr_o, wdata_o;
    logic        rw_o, valid_o;
    logic [15:0] bus_rdata_i;
    logic        bus_rw_i, bus_valid_i;
    logic        a_overflow_o, b_overflow_o, spurious_o;
    logic [15:0] a_grants_o, b_grants_o;

    logic        auto_resp;
    logic        m_valid;
    logic [15:0] m_rdata;

    int errors = 0;
    int checks = 0;

    logic [15:0] a_q[$];
    logic [15:0] b_q[$];
    logic [15:0] iss_q[$];

    bus_arbiter #(
        .ADDR_W          (16),
        .DATA_W          (16),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .a_addr_i     (a_addr_i),
        .a_wdata_i    (a_wdata_i),
        .a_rw_i       (a_rw_i),
        .a_valid_i    (a_valid_i),
        .b_addr_i     (b_addr_i),
        .b_wdata_i    (b_wdata_i),
        .b_rw_i       (b_rw_i),
        .b_valid_i    (b_valid_i),
        .a_rdata_o    (a_rdata_o),
        .a_rw_o       (a_rw_o),
        .a_valid_o    (a_valid_o),
        .b_rdata_o    (b_rdata_o),
        .b_rw_o       (b_rw_o),
        .b_valid_o    (b_valid_o),
        .addr_o       (addr_o),
        .wdata_o      (wdata_o),
        .rw_o         (rw_o),
        .valid_o      (valid_o),
        .bus_rdata_i  (bus_rdata_i),
        .bus_rw_i     (bus_rw_i),
        .bus_valid_i  (bus_valid_i),
        .a_overflow_o (a_overflow_o),
        .b_overflow_o (b_overflow_o),
        .spurious_o   (spurious_o),
        .a_grants_o   (a_grants_o),
        .b_grants_o   (b_grants_o)
    );

    always #5 clk = ~clk;

    // Chain model: lut_mem DEPTH 32 with mem[i]=i answering in the issue cycle,
    // or manually driven responses when withheld.
    always_comb begin
        if (auto_resp) begin
            bus_valid_i = valid_o;
            bus_rdata_i = {11'd0, addr_o[4:0]};
            bus_rw_i    = rw_o;
        end else begin
            bus_valid_i = m_valid;
            bus_rdata_i = m_rdata;
            bus_rw_i    = 1'b0;
        end
    end

    // Record issued addresses and routed responses.
    always @(posedge clk) begin
        if (!rst) begin
            if (valid_o)   iss_q.push_back(addr_o);
            if (a_valid_o) a_q.push_back(a_rdata_o);
            if (b_valid_o) b_q.push_back(b_rdata_o);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        a_valid_i = 1'b0; b_valid_i = 1'b0;
        a_addr_i  = '0;   b_addr_i  = '0;
        a_wdata_i = '0;   b_wdata_i = '0;
        a_rw_i    = 1'b0; b_rw_i    = 1'b0;
        m_valid   = 1'b0; m_rdata   = '0;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        a_q.delete(); b_q.delete(); iss_q.delete();
    endtask

    task automatic test_reset();
        auto_resp = 1'b1;
        do_reset();
        checks++;
        if ({valid_o, addr_o, wdata_o, rw_o} !== '0) begin
            errors++;
            $display("FAIL reset_bus: got %h, want 0", {valid_o, addr_o, wdata_o, rw_o});
        end
        checks++;
        if ({a_valid_o, a_rdata_o, a_rw_o, b_valid_o, b_rdata_o, b_rw_o} !== '0) begin
            errors++;
            $display("FAIL reset_resp: got %h, want 0",
                     {a_valid_o, a_rdata_o, a_rw_o, b_valid_o, b_rdata_o, b_rw_o});
        end
        checks++;
        if ({a_overflow_o, b_overflow_o, spurious_o, a_grants_o, b_grants_o} !== '0) begin
            errors++;
            $display("FAIL reset_flags: got %h, want 0",
                     {a_overflow_o, b_overflow_o, spurious_o, a_grants_o, b_grants_o});
        end
    endtask

    task automatic test_single();
        auto_resp = 1'b1;
        do_reset();
        a_addr_i = 16'h0001; a_rw_i = 1'b0; a_valid_i = 1'b1;
        cyc();
        a_valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || addr_o !== 16'h0001 || rw_o !== 1'b0) begin
            errors++;
            $display("FAIL single_issue: valid=%b addr=%h rw=%b, want 1 0001 0", valid_o, addr_o, rw_o);
        end
        cyc();
        checks++;
        if (a_valid_o !== 1'b1 || a_rdata_o !== 16'h0001 || b_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_resp: a_valid=%b a_rdata=%h b_valid=%b, want 1 0001 0",
                     a_valid_o, a_rdata_o, b_valid_o);
        end
        cyc(3);
        checks++;
        if (a_q.size() != 1 || b_q.size() != 0 || iss_q.size() != 1) begin
            errors++;
            $display("FAIL single_counts: a=%0d b=%0d issued=%0d, want 1 0 1",
                     a_q.size(), b_q.size(), iss_q.size());
        end
    endtask

    task automatic test_simultaneous();
        auto_resp = 1'b1;
        do_reset();
        a_addr_i = 16'h0003; b_addr_i = 16'h0005;
        a_valid_i = 1'b1; b_valid_i = 1'b1;
        cyc();
        a_valid_i = 1'b0; b_valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || addr_o !== 16'h0003) begin
            errors++;
            $display("FAIL sim_first: valid=%b addr=%h, want 1 0003", valid_o, addr_o);
        end
        cyc();
        checks++;
        if (valid_o !== 1'b1 || addr_o !== 16'h0005 || a_valid_o !== 1'b1 || a_rdata_o !== 16'h0003) begin
            errors++;
            $display("FAIL sim_second: valid=%b addr=%h a_valid=%b a_rdata=%h, want 1 0005 1 0003",
                     valid_o, addr_o, a_valid_o, a_rdata_o);
        end
        cyc();
        checks++;
        if (b_valid_o !== 1'b1 || b_rdata_o !== 16'h0005 || a_valid_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL sim_route_b: b_valid=%b b_rdata=%h a_valid=%b valid=%b, want 1 0005 0 0",
                     b_valid_o, b_rdata_o, a_valid_o, valid_o);
        end
    endtask

    task automatic test_contention();
        int bad;
        int exp_g;
        auto_resp = 1'b1;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            a_addr_i = 16'(i % 16);
            b_addr_i = 16'(16 + i % 16);
            a_valid_i = 1'b1; b_valid_i = 1'b1;
            cyc();
            a_valid_i = 1'b0; b_valid_i = 1'b0;
            cyc();
        end
        cyc(4);
        checks++;
        if (iss_q.size() != 200) begin
            errors++;
            $display("FAIL cont_issued: got %0d, want 200", iss_q.size());
        end
        bad = 0;
        for (int i = 0; i < 100 && 2 * i + 1 < iss_q.size(); i++) begin
            if (iss_q[2*i] !== 16'(i % 16) || iss_q[2*i+1] !== 16'(16 + i % 16)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL cont_alternate: %0d misordered grant pairs, want 0", bad);
        end
        bad = 0;
        for (int i = 0; i < a_q.size(); i++) if (a_q[i] !== 16'(i % 16)) bad++;
        for (int i = 0; i < b_q.size(); i++) if (b_q[i] !== 16'(16 + i % 16)) bad++;
        checks++;
        if (a_q.size() != 100 || b_q.size() != 100 || bad != 0) begin
            errors++;
            $display("FAIL cont_responses: a=%0d b=%0d wrong=%0d, want 100 100 0",
                     a_q.size(), b_q.size(), bad);
        end
        checks++;
        if (a_overflow_o !== 1'b0 || b_overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL cont_overflow: a=%b b=%b, want 0 0", a_overflow_o, b_overflow_o);
        end
`ifdef BUS_ARBITER_STATS_EN
        exp_g = 100;
`else
        exp_g = 0;
`endif
        checks++;
        if (a_grants_o !== 16'(exp_g) || b_grants_o !== 16'(exp_g)) begin
            errors++;
            $display("FAIL cont_grants: a=%0d b=%0d, want %0d %0d", a_grants_o, b_grants_o, exp_g, exp_g);
        end
    endtask

    task automatic test_overflow();
        auto_resp = 1'b1;
        do_reset();
        // One lone A grant leaves the pointer on A so B wins the first tie.
        a_addr_i = 16'h0002; a_valid_i = 1'b1;
        cyc();
        a_valid_i = 1'b0;
        cyc(3);
        a_q.delete(); b_q.delete(); iss_q.delete();
        for (int i = 0; i < 3; i++) begin
            a_addr_i = 16'(4 + i);
            b_addr_i = 16'(20 + i);
            a_valid_i = 1'b1; b_valid_i = 1'b1;
            cyc();
            if (i == 1) begin
                checks++;
                if (a_overflow_o !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_early: a_overflow=%b, want 0", a_overflow_o);
                end
            end
        end
        a_valid_i = 1'b0; b_valid_i = 1'b0;
        checks++;
        if (a_overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: a_overflow=%b, want 1", a_overflow_o);
        end
        cyc(8);
        checks++;
        if (iss_q.size() != 5 || iss_q[0] !== 16'd20 || iss_q[1] !== 16'd4 || iss_q[2] !== 16'd21
            || iss_q[3] !== 16'd5 || iss_q[4] !== 16'd22) begin
            errors++;
            $display("FAIL ovf_order: issued=%0d %p, want 20 4 21 5 22", iss_q.size(), iss_q);
        end
        checks++;
        if (a_q.size() != 2 || b_q.size() != 3 || a_overflow_o !== 1'b1 || b_overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_persist: a=%0d b=%0d a_ovf=%b b_ovf=%b, want 2 3 1 0",
                     a_q.size(), b_q.size(), a_overflow_o, b_overflow_o);
        end
        do_reset();
        checks++;
        if (a_overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: a_overflow=%b, want 0", a_overflow_o);
        end
    endtask

    task automatic test_full_spurious();
        auto_resp = 1'b0;
        do_reset();
        a_valid_i = 1'b1; a_addr_i = 16'd7;
        cyc();
        checks++;
        if (valid_o !== 1'b1 || addr_o !== 16'd7) begin
            errors++;
            $display("FAIL full_issue0: valid=%b addr=%h, want 1 0007", valid_o, addr_o);
        end
        a_addr_i = 16'd8;
        cyc();
        a_addr_i = 16'd9;
        cyc();
        a_valid_i = 1'b0;
        cyc(3);
        checks++;
        if (valid_o !== 1'b0 || iss_q.size() != 2 || a_overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL full_block: valid=%b issued=%0d ovf=%b, want 0 2 0",
                     valid_o, iss_q.size(), a_overflow_o);
        end
        m_valid = 1'b1; m_rdata = 16'd7;
        cyc();
        m_valid = 1'b0;
        checks++;
        if (a_valid_o !== 1'b1 || a_rdata_o !== 16'd7 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL full_pop0: a_valid=%b a_rdata=%h valid=%b, want 1 0007 0",
                     a_valid_o, a_rdata_o, valid_o);
        end
        cyc();
        checks++;
        if (valid_o !== 1'b1 || addr_o !== 16'd9) begin
            errors++;
            $display("FAIL full_third: valid=%b addr=%h, want 1 0009", valid_o, addr_o);
        end
        for (int i = 0; i < 2; i++) begin
            m_valid = 1'b1; m_rdata = 16'(8 + i);
            cyc();
            m_valid = 1'b0;
            checks++;
            if (a_valid_o !== 1'b1 || a_rdata_o !== 16'(8 + i)) begin
                errors++;
                $display("FAIL full_drain%0d: a_valid=%b a_rdata=%h, want 1 %h",
                         i, a_valid_o, a_rdata_o, 16'(8 + i));
            end
        end
        cyc();
        checks++;
        if (spurious_o !== 1'b0) begin
            errors++;
            $display("FAIL full_nospur: spurious=%b, want 0", spurious_o);
        end
        m_valid = 1'b1; m_rdata = 16'hDEAD;
        cyc();
        m_valid = 1'b0;
        checks++;
        if (spurious_o !== 1'b1 || a_valid_o !== 1'b0 || b_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL full_spurious: spurious=%b a_valid=%b b_valid=%b, want 1 0 0",
                     spurious_o, a_valid_o, b_valid_o);
        end
    endtask

    task automatic test_reset_midflight();
        auto_resp = 1'b0;
        do_reset();
        a_addr_i = 16'd10; b_addr_i = 16'd11;
        a_valid_i = 1'b1; b_valid_i = 1'b1;
        cyc();
        a_valid_i = 1'b0; b_valid_i = 1'b0;
        cyc();
        checks++;
        if (valid_o !== 1'b1 || addr_o !== 16'd11) begin
            errors++;
            $display("FAIL mid_issue: valid=%b addr=%h, want 1 000b", valid_o, addr_o);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if ({valid_o, addr_o, a_valid_o, b_valid_o, a_rdata_o, b_rdata_o, spurious_o, a_overflow_o} !== '0) begin
            errors++;
            $display("FAIL mid_outputs: got %h, want 0",
                     {valid_o, addr_o, a_valid_o, b_valid_o, a_rdata_o, b_rdata_o, spurious_o, a_overflow_o});
        end
        m_valid = 1'b1; m_rdata = 16'd10;
        cyc();
        checks++;
        if (spurious_o !== 1'b1 || a_valid_o !== 1'b0 || b_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_late0: spurious=%b a_valid=%b b_valid=%b, want 1 0 0",
                     spurious_o, a_valid_o, b_valid_o);
        end
        m_rdata = 16'd11;
        cyc();
        m_valid = 1'b0;
        cyc();
        checks++;
        if (spurious_o !== 1'b1 || a_q.size() != 0 || b_q.size() != 0) begin
            errors++;
            $display("FAIL mid_late1: spurious=%b a=%0d b=%0d, want 1 0 0",
                     spurious_o, a_q.size(), b_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        auto_resp = 1'b1;
        test_reset();
        test_single();
        test_simultaneous();
        test_contention();
        test_overflow();
        test_full_spurious();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
